fetch_unit: RTL and testbench

//   Instruction-fetch stage directly upstream of imem. Owns the PC, drives imem's

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives imem combinationally and registers the returned word into IF/ID.
// Latency 1 cycle (word at pc appears on if_id_* after the next edge); stall holds pc/IF/ID, redirect flushes.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS     = 64,
    parameter bit          HALT_ON_EBREAK = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic [31:0] if_id_instr,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [31:0] RANGE_BYTES  = 32'(4 * IMEM_WORDS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic [31:0] if_id_pc_plus4_q, if_id_pc_plus4_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        pc_in_range;
    logic        target_legal;
    logic        is_ebreak;
    logic [31:0] pc_plus4;

    // Offset subtraction wraps, so addresses below RESET_PC fail the compare too.
    function automatic logic in_range(input logic [31:0] addr);
        return (addr - RESET_PC) < RANGE_BYTES;
    endfunction

    always_comb begin
        pc_in_range  = in_range(pc_q);
        target_legal = (redirect_target[1:0] == 2'b00) && in_range(redirect_target);
        is_ebreak    = HALT_ON_EBREAK && (imem_rd == EBREAK_INSTR);
        pc_plus4     = pc_q + 32'd4;
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        if_id_valid_d    = if_id_valid_q;
        if_id_pc_d       = if_id_pc_q;
        if_id_pc_plus4_d = if_id_pc_plus4_q;
        if_id_instr_d    = if_id_instr_q;
        fault_pc_d       = fault_pc_q;
        fetch_count_d    = fetch_count_q;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    if (target_legal) begin
                        pc_d = redirect_target;
                    end else begin
                        state_d    = ST_FAULT;
                        fault_pc_d = redirect_target;
                    end
                end else if (!stall) begin
                    if (!pc_in_range) begin
                        state_d       = ST_FAULT;
                        fault_pc_d    = pc_q;
                        if_id_valid_d = 1'b0;
                        if_id_instr_d = NOP_INSTR;
                    end else begin
                        if_id_valid_d    = 1'b1;
                        if_id_pc_d       = pc_q;
                        if_id_pc_plus4_d = pc_plus4;
                        if_id_instr_d    = imem_rd;
                        fetch_count_d    = fetch_count_q + 32'd1;
                        // EBREAK is delivered to decode but the PC parks on it.
                        if (is_ebreak) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end
            end
            ST_HALT: begin
                if (redirect) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                    if (target_legal) begin
                        pc_d    = redirect_target;
                        state_d = ST_RUN;
                    end else begin
                        state_d    = ST_FAULT;
                        fault_pc_d = redirect_target;
                    end
                end else if (!stall) begin
                    if_id_valid_d = 1'b0;
                    if_id_instr_d = NOP_INSTR;
                end
            end
            ST_FAULT: begin
                if_id_valid_d = 1'b0;
            end
            default: begin
                state_d       = ST_FAULT;
                fault_pc_d    = pc_q;
                if_id_valid_d = 1'b0;
                if_id_instr_d = NOP_INSTR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            if_id_valid_q    <= 1'b0;
            if_id_pc_q       <= 32'd0;
            if_id_pc_plus4_q <= 32'd0;
            if_id_instr_q    <= NOP_INSTR;
            fault_pc_q       <= 32'd0;
            fetch_count_q    <= 32'd0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_id_valid_q    <= if_id_valid_d;
            if_id_pc_q       <= if_id_pc_d;
            if_id_pc_plus4_q <= if_id_pc_plus4_d;
            if_id_instr_q    <= if_id_instr_d;
            fault_pc_q       <= fault_pc_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign imem_a         = pc_q;
    assign if_id_valid    = if_id_valid_q;
    assign if_id_pc       = if_id_pc_q;
    assign if_id_pc_plus4 = if_id_pc_plus4_q;
    assign if_id_instr    = if_id_instr_q;
    assign halted         = (state_q == ST_HALT);
    assign fault          = (state_q == ST_FAULT);
    assign fault_pc       = fault_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected IF/ID captures plus state/boundary checks.
module tb_fetch_unit;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        halted;
    logic        fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:63];
    logic [31:0] exp_pc;
    logic [31:0] exp_count;
    int          n_checks;
    int          n_fail;

    fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .IMEM_WORDS    (64),
        .HALT_ON_EBREAK(1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_a         (imem_a),
        .imem_rd        (imem_rd),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_instr    (if_id_instr),
        .halted         (halted),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    assign imem_rd = (imem_a < 32'd256) ? mem[imem_a[7:2]] : 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] t);
        stall           = s;
        redirect        = r;
        redirect_target = t;
        @(posedge clk);
        #1;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'd0;
    endtask

    task automatic chk_reset_state();
        chk("rst_imem_a", imem_a, 32'd0);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_if_id_pc", if_id_pc, 32'd0);
        chk("rst_pc_plus4", if_id_pc_plus4, 32'd0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_fetch_count", fetch_count, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(1'b0, 1'b0, 32'd0);
        reset_n = 1'b1;
        sb_q.delete();
        exp_pc    = 32'd0;
        exp_count = 32'd0;
    endtask

    // Each advance pushes the word the bench expects at exp_pc, then pops it after the edge.
    task automatic adv(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            chk("adv_imem_a", imem_a, exp_pc);
            sb_q.push_back('{pc: exp_pc, instr: mem[exp_pc[7:2]]});
            cyc(1'b0, 1'b0, 32'd0);
            exp_count = exp_count + 32'd1;
            chk("adv_valid", 32'(if_id_valid), 32'd1);
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_if_id_pc", if_id_pc, e.pc);
                chk("sb_pc_plus4", if_id_pc_plus4, e.pc + 32'd4);
                chk("sb_instr", if_id_instr, e.instr);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset_n         = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i * 4);

        // Free-run through the whole imem, then step off the end.
        do_reset();
        chk_reset_state();
        adv(64);
        chk("t1_fetch_count", fetch_count, 32'd64);
        chk("t1_imem_a_end", imem_a, 32'd256);
        chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        chk("t1_fault", 32'(fault), 32'd1);
        chk("t1_fault_pc", fault_pc, 32'd256);
        chk("t1_valid", 32'(if_id_valid), 32'd0);
        chk("t1_halted", 32'(halted), 32'd0);
        chk("t1_pc_held", imem_a, 32'd256);
        chk("t1_count_held", fetch_count, 32'd64);

        // Stall holds everything.
        do_reset();
        adv(4);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 32'd0);
            chk("t2_imem_a", imem_a, 32'h10);
            chk("t2_if_id_pc", if_id_pc, 32'h0C);
            chk("t2_instr", if_id_instr, 32'h0C);
            chk("t2_count", fetch_count, 32'd4);
        end
        adv(1);
        chk("t2_count_after", fetch_count, 32'd5);

        // Redirect beats stall and flushes IF/ID.
        do_reset();
        adv(2);
        cyc(1'b1, 1'b1, 32'h40);
        chk("t3_imem_a", imem_a, 32'h40);
        chk("t3_valid", 32'(if_id_valid), 32'd0);
        chk("t3_instr", if_id_instr, NOP);
        chk("t3_count", fetch_count, 32'd2);
        exp_pc = 32'h40;
        adv(1);

        // Misaligned redirect faults; fault is sticky until reset.
        cyc(1'b0, 1'b1, 32'h42);
        chk("t4_fault", 32'(fault), 32'd1);
        chk("t4_fault_pc", fault_pc, 32'h42);
        chk("t4_valid", 32'(if_id_valid), 32'd0);
        cyc(1'b0, 1'b1, 32'h10);
        cyc(1'b1, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 32'd0);
        chk("t4_fault_sticky", 32'(fault), 32'd1);
        chk("t4_fault_pc_held", fault_pc, 32'h42);
        chk("t4_pc_held", imem_a, 32'h44);
        do_reset();
        chk("t4_fault_cleared", 32'(fault), 32'd0);
        chk("t4_pc_reset", imem_a, 32'd0);

        // Last legal word accepted, first word past the end faults.
        cyc(1'b0, 1'b1, 32'hFC);
        chk("t4b_imem_a", imem_a, 32'hFC);
        chk("t4b_fault", 32'(fault), 32'd0);
        cyc(1'b0, 1'b1, 32'h100);
        chk("t4b_fault_oor", 32'(fault), 32'd1);
        chk("t4b_fault_pc", fault_pc, 32'h100);

        // EBREAK halts with the PC parked on it; redirect resumes.
        mem[8] = EBREAK;
        do_reset();
        adv(9);
        chk("t5_instr", if_id_instr, EBREAK);
        chk("t5_halted", 32'(halted), 32'd1);
        chk("t5_imem_a", imem_a, 32'h20);
        chk("t5_count", fetch_count, 32'd9);
        cyc(1'b0, 1'b0, 32'd0);
        chk("t5_valid_drop", 32'(if_id_valid), 32'd0);
        chk("t5_nop", if_id_instr, NOP);
        chk("t5_still_halted", 32'(halted), 32'd1);
        chk("t5_pc_parked", imem_a, 32'h20);
        chk("t5_count_held", fetch_count, 32'd9);
        cyc(1'b0, 1'b1, 32'h24);
        chk("t5_resumed", 32'(halted), 32'd0);
        chk("t5_resume_pc", imem_a, 32'h24);
        exp_pc    = 32'h24;
        exp_count = fetch_count;
        adv(2);
        chk("t5_count_final", fetch_count, 32'd11);
        mem[8] = 32'h20;

        // Reset mid-stream overrides a simultaneous redirect.
        do_reset();
        adv(12);
        chk("t6_pc_before", imem_a, 32'h30);
        reset_n = 1'b0;
        cyc(1'b0, 1'b1, 32'h40);
        reset_n = 1'b1;
        chk_reset_state();
        sb_q.delete();
        exp_pc    = 32'd0;
        exp_count = 32'd0;
        adv(1);
        chk("t6_count", fetch_count, exp_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
